enable_seq_monitor: RTL and testbench

- Receive-side checker for the staggered three-enable sequence, clocked in the clkB domain.
- Samples ena_1/ena_2/ena_3 as delivered after synchronization and verifies the legal pattern order 000 -> 111 -> 011 -> 001 -> 000.
- Counts completed sequences and flags the first protocol violation (bad start, illegal transition, stuck phase).
- Provides an on-chip pass/fail readout for the synchronizer test structure.

---
 rtl/enable_seq_monitor.sv | 181 ++++++++++++++++++
 tb/tb_enable_seq_monitor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/enable_seq_monitor.sv
// Receive-side checker for the staggered three-enable sequence (clkB domain).
// Tracks 000 -> 111 -> 011 -> 001 -> 000, counts completions, latches first error.
module enable_seq_monitor #(
    parameter int CNT_W   = 8,
    parameter int TO_W    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clkB,
    input  logic             rst,
    input  logic             ena_1,
    input  logic             ena_2,
    input  logic             ena_3,
    input  logic             clr,
    output logic             seq_done,
    output logic [CNT_W-1:0] seq_count,
    output logic             busy,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_P1   = 2'd1,
        S_P2   = 2'd2,
        S_P3   = 2'd3
    } state_t;

    localparam logic [2:0] E_NONE      = 3'd0;
    localparam logic [2:0] E_BAD_START = 3'd1;
    localparam logic [2:0] E_ILLEGAL   = 3'd2;
    localparam logic [2:0] E_ABORT     = 3'd3;
    localparam logic [2:0] E_TIMEOUT   = 3'd4;

    localparam logic [2:0] PAT_IDLE = 3'b000;
    localparam logic [2:0] PAT_P1   = 3'b111;
    localparam logic [2:0] PAT_P2   = 3'b011;
    localparam logic [2:0] PAT_P3   = 3'b001;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);
    localparam bit              TO_EN  = (TIMEOUT != 0);

    logic [2:0]       pat_d;
    logic [2:0]       pat_q;
    state_t           state_d;
    state_t           state_q;
    logic [TO_W-1:0]  hold_d;
    logic [TO_W-1:0]  hold_q;
    logic             done_d;
    logic             done_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             err_d;
    logic             err_q;
    logic [2:0]       code_d;
    logic [2:0]       code_q;
    logic [2:0]       phase_pat;
    logic             held;
    logic [2:0]       ev;

    assign pat_d = {ena_1, ena_2, ena_3};

    always_comb begin
        phase_pat = PAT_IDLE;
        unique case (state_q)
            S_IDLE: phase_pat = PAT_IDLE;
            S_P1:   phase_pat = PAT_P1;
            S_P2:   phase_pat = PAT_P2;
            S_P3:   phase_pat = PAT_P3;
        endcase
    end

    // Only non-idle phases are timed; IDLE may sit on 000 forever.
    assign held = (state_q != S_IDLE) && (pat_q == phase_pat);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        ev      = E_NONE;
        if (held) begin
            if (TO_EN && (hold_q == TO_LIM)) begin
                ev      = E_TIMEOUT;
                state_d = S_IDLE;
                hold_d  = '0;
            end else if (hold_q != '1) begin
                hold_d = hold_q + TO_W'(1);
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    hold_d = '0;
                    if (pat_q == PAT_P1) begin
                        state_d = S_P1;
                        hold_d  = TO_W'(1);
                    end else if (pat_q != PAT_IDLE) begin
                        ev = E_BAD_START;
                    end
                end
                S_P1: begin
                    if (pat_q == PAT_P2) begin
                        state_d = S_P2;
                        hold_d  = TO_W'(1);
                    end else begin
                        state_d = S_IDLE;
                        hold_d  = '0;
                        ev      = (pat_q == PAT_IDLE) ? E_ABORT : E_ILLEGAL;
                    end
                end
                S_P2: begin
                    if (pat_q == PAT_P3) begin
                        state_d = S_P3;
                        hold_d  = TO_W'(1);
                    end else begin
                        state_d = S_IDLE;
                        hold_d  = '0;
                        ev      = (pat_q == PAT_IDLE) ? E_ABORT : E_ILLEGAL;
                    end
                end
                S_P3: begin
                    state_d = S_IDLE;
                    hold_d  = '0;
                    if (pat_q == PAT_IDLE) begin
                        done_d = 1'b1;
                    end else begin
                        ev = E_ILLEGAL;
                    end
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (done_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // clr drops the flag first, so an error on the same edge is still captured.
    always_comb begin
        err_d  = err_q;
        code_d = code_q;
        if (clr) begin
            err_d  = 1'b0;
            code_d = E_NONE;
        end
        if ((ev != E_NONE) && !err_d) begin
            err_d  = 1'b1;
            code_d = ev;
        end
    end

    always_ff @(posedge clkB) begin
        if (rst) begin
            pat_q   <= '0;
            state_q <= S_IDLE;
            hold_q  <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= E_NONE;
        end else begin
            pat_q   <= pat_d;
            state_q <= state_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign seq_done  = done_q;
    assign seq_count = cnt_q;
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;
    assign err_code  = code_q;
    assign state     = state_q;

endmodule

// File: tb/tb_enable_seq_monitor.sv
// Scoreboard bench for enable_seq_monitor: directed vectors push expectations,
// a monitor pops and compares them after the edge they describe.
module tb_enable_seq_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_s = 1'b1;
    logic clr_s = 1'b0;
    logic e1 = 1'b0;
    logic e2 = 1'b0;
    logic e3 = 1'b0;

    logic       done_a, busy_a, err_a;
    logic [7:0] cnt_a;
    logic [2:0] code_a;
    logic [1:0] st_a;

    logic       done_b, busy_b, err_b;
    logic [1:0] cnt_b;
    logic [2:0] code_b;
    logic [1:0] st_b;

    enable_seq_monitor dut (
        .clkB(clk), .rst(rst_s),
        .ena_1(e1), .ena_2(e2), .ena_3(e3),
        .clr(clr_s),
        .seq_done(done_a), .seq_count(cnt_a),
        .busy(busy_a), .err(err_a),
        .err_code(code_a), .state(st_a)
    );

    enable_seq_monitor #(.CNT_W(2)) dut_s (
        .clkB(clk), .rst(rst_s),
        .ena_1(e1), .ena_2(e2), .ena_3(e3),
        .clr(clr_s),
        .seq_done(done_b), .seq_count(cnt_b),
        .busy(busy_b), .err(err_b),
        .err_code(code_b), .state(st_b)
    );

    typedef struct {
        int cyc;
        int st;
        int dn;
        int er;
        int cd;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   ecnt  = 0;
    int   total = 0;
    int   bad   = 0;
    bit   nxt_clr = 1'b0;
    bit   nxt_rst = 1'b1;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string nm, input int cyc,
                       input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0d want=%0d",
                     nm, cyc, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t x;
        int   sc;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0 && q[0].cyc <= ecnt) begin
                x = q.pop_front();
                if (x.cyc < ecnt) begin
                    chk("missed_slot", x.cyc, ecnt, x.cyc);
                end else begin
                    sc = (x.cnt > 3) ? 3 : x.cnt;
                    chk("state", x.cyc, int'(st_a), x.st);
                    chk("busy", x.cyc, int'(busy_a), int'(x.st != 0));
                    chk("seq_done", x.cyc, int'(done_a), x.dn);
                    chk("err", x.cyc, int'(err_a), x.er);
                    chk("err_code", x.cyc, int'(code_a), x.cd);
                    chk("seq_count", x.cyc, int'(cnt_a), x.cnt);
                    chk("s_state", x.cyc, int'(st_b), x.st);
                    chk("s_busy", x.cyc, int'(busy_b), int'(x.st != 0));
                    chk("s_seq_done", x.cyc, int'(done_b), x.dn);
                    chk("s_err", x.cyc, int'(err_b), x.er);
                    chk("s_err_code", x.cyc, int'(code_b), x.cd);
                    chk("s_seq_count", x.cyc, int'(cnt_b), sc);
                end
            end
        end
    end

    // Pattern p is sampled on the next edge and acted on one edge later;
    // c/r are lined up with that second edge, where the expectation applies.
    task automatic vec(input logic [2:0] p, input bit c, input bit r,
                       input int st, input int dn, input int er,
                       input int cd, input int cnt);
        exp_t x;
        @(negedge clk);
        {e1, e2, e3} = p;
        clr_s   = nxt_clr;
        rst_s   = nxt_rst;
        nxt_clr = c;
        nxt_rst = r;
        x.cyc = ecnt + 2;
        x.st  = st;
        x.dn  = dn;
        x.er  = er;
        x.cd  = cd;
        x.cnt = cnt;
        q.push_back(x);
    endtask

    task automatic seq(input int er, input int cd, input int cnt);
        vec(3'b111, 0, 0, 1, 0, er, cd, cnt - 1);
        vec(3'b011, 0, 0, 2, 0, er, cd, cnt - 1);
        vec(3'b001, 0, 0, 3, 0, er, cd, cnt - 1);
        vec(3'b000, 0, 0, 0, 1, er, cd, cnt);
    endtask

    initial begin
        vec(3'b000, 0, 1, 0, 0, 0, 0, 0);

        repeat (2) vec(3'b000, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) vec(3'b111, 0, 0, 1, 0, 0, 0, 0);
        repeat (3) vec(3'b011, 0, 0, 2, 0, 0, 0, 0);
        vec(3'b001, 0, 0, 3, 0, 0, 0, 0);
        vec(3'b000, 0, 0, 0, 1, 0, 0, 1);
        vec(3'b000, 0, 0, 0, 0, 0, 0, 1);

        vec(3'b011, 0, 0, 0, 0, 1, 1, 1);
        vec(3'b000, 0, 0, 0, 0, 1, 1, 1);
        seq(1, 1, 2);
        vec(3'b000, 1, 0, 0, 0, 0, 0, 2);

        vec(3'b111, 0, 0, 1, 0, 0, 0, 2);
        vec(3'b001, 0, 0, 0, 0, 1, 2, 2);
        vec(3'b101, 0, 0, 0, 0, 1, 2, 2);
        vec(3'b000, 0, 0, 0, 0, 1, 2, 2);
        vec(3'b000, 1, 0, 0, 0, 0, 0, 2);

        vec(3'b111, 0, 0, 1, 0, 0, 0, 2);
        vec(3'b011, 0, 0, 2, 0, 0, 0, 2);
        vec(3'b000, 0, 0, 0, 0, 1, 3, 2);
        vec(3'b000, 1, 0, 0, 0, 0, 0, 2);

        repeat (15) vec(3'b111, 0, 0, 1, 0, 0, 0, 2);
        vec(3'b111, 0, 0, 0, 0, 1, 4, 2);
        vec(3'b000, 0, 0, 0, 0, 1, 4, 2);
        vec(3'b000, 1, 0, 0, 0, 0, 0, 2);

        repeat (15) vec(3'b111, 0, 0, 1, 0, 0, 0, 2);
        vec(3'b011, 0, 0, 2, 0, 0, 0, 2);
        vec(3'b001, 0, 0, 3, 0, 0, 0, 2);
        vec(3'b000, 0, 0, 0, 1, 0, 0, 3);

        vec(3'b001, 0, 0, 0, 0, 1, 1, 3);
        vec(3'b000, 0, 0, 0, 0, 1, 1, 3);
        vec(3'b111, 0, 0, 1, 0, 1, 1, 3);
        vec(3'b110, 1, 0, 0, 0, 1, 2, 3);
        vec(3'b000, 1, 0, 0, 0, 0, 0, 3);

        vec(3'b000, 0, 1, 0, 0, 0, 0, 0);
        vec(3'b000, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) seq(0, 0, k);

        vec(3'b111, 0, 0, 1, 0, 0, 0, 5);
        vec(3'b011, 0, 0, 2, 0, 0, 0, 5);
        vec(3'b011, 0, 1, 0, 0, 0, 0, 0);
        vec(3'b000, 0, 0, 0, 0, 0, 0, 0);
        vec(3'b000, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        clr_s = nxt_clr;
        rst_s = nxt_rst;
        for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
